mcu_run_monitor: RTL

Parametrised run-control and trace block for the MCU cores. It holds the core in clear, releases it, and clock-enables it while recording every executed cycle's `{PC_next, write_back_data}` into a circular trace buffer. Execution halts on a PC breakpoint, a stall (PC self-loop) or a cycle budget, and the captured history can then be read out. It sits between the top-level clock/clear and a core such as the single-cycle MCU. It turns the free-running bench stimulus into a synthesizable, bounded, inspectable run.

---
 rtl/mcu_run_monitor_if.sv | 36 +++
 rtl/mcu_run_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mcu_run_monitor_if.sv
// Run-monitor signal bundle: start/breakpoint control, core-facing sample
// and clear/enable lines, run status and the trace readout port.
interface mcu_run_monitor_if #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TRACE_DEPTH = 16
);
    localparam int unsigned CNT_W = $clog2(TRACE_DEPTH) + 1;

    logic                     start;
    logic                     bp_en;
    logic [ADDR_W-1:0]        bp_addr;
    logic [ADDR_W-1:0]        PC_next;
    logic [DATA_W-1:0]        write_back_data;
    logic                     core_nClear;
    logic                     core_en;
    logic                     halted;
    logic [1:0]               halt_cause;
    logic [31:0]              cycle_count;
    logic [CNT_W-1:0]         trace_count;
    logic                     rd_en;
    logic [ADDR_W+DATA_W-1:0] rd_data;
    logic                     rd_valid;

    modport master (
        output start, bp_en, bp_addr, PC_next, write_back_data, rd_en,
        input  core_nClear, core_en, halted, halt_cause, cycle_count,
               trace_count, rd_data, rd_valid
    );

    modport slave (
        input  start, bp_en, bp_addr, PC_next, write_back_data, rd_en,
        output core_nClear, core_en, halted, halt_cause, cycle_count,
               trace_count, rd_data, rd_valid
    );
endinterface

// File: rtl/mcu_run_monitor.sv
// Run-control and trace block: holds the core in clear, releases it, enables
// it while recording {PC_next, write_back_data} per cycle into a circular
// buffer, halts on breakpoint / stall / cycle budget, and allows readout.
module mcu_run_monitor #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned STALL_LIMIT = 4,
    parameter int unsigned MAX_CYCLES  = 65535
) (
    input logic              clk,
    input logic              Clear,
    mcu_run_monitor_if.slave bus
);
    localparam int unsigned PTR_W   = $clog2(TRACE_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENT_W   = ADDR_W + DATA_W;
    localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [CNT_W-1:0]   FULL      = CNT_W'(TRACE_DEPTH);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [STALL_W-1:0] STALL_HIT = STALL_W'(STALL_LIMIT - 1);
    localparam logic [32:0]        BUDGET    = 33'(MAX_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        RESET_HOLD,
        RUN,
        HALTED
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_BP,
        CAUSE_STALL,
        CAUSE_BUDGET
    } cause_e;

    state_e             state_q, state_d;
    cause_e             cause_q, cause_d;
    logic [HOLD_W-1:0]  hold_q;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [ADDR_W-1:0]  prev_pc_q;
    logic               first_q;
    logic [31:0]        cyc_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ENT_W-1:0]   mem [TRACE_DEPTH];
    logic [ENT_W-1:0]   rd_data_q;
    logic               rd_valid_q;
    logic               nclr_q;

    logic launch;
    logic sample;
    logic do_read;

    // Next-state, halt decision and per-cycle action strobes
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        stall_d = stall_q;
        launch  = 1'b0;
        sample  = 1'b0;
        do_read = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RESET_HOLD;
                    launch  = 1'b1;
                end else if (bus.rd_en && (cnt_q != '0)) begin
                    do_read = 1'b1;
                end
            end
            RESET_HOLD: begin
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                sample = 1'b1;
                if (first_q || (bus.PC_next != prev_pc_q)) begin
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
                if (bus.bp_en && (bus.PC_next == bus.bp_addr)) begin
                    state_d = HALTED;
                    cause_d = CAUSE_BP;
                end else if (stall_d == STALL_HIT) begin
                    state_d = HALTED;
                    cause_d = CAUSE_STALL;
                end else if (({1'b0, cyc_q} + 33'd1) == BUDGET) begin
                    state_d = HALTED;
                    cause_d = CAUSE_BUDGET;
                end
            end
            HALTED: begin
                // start takes precedence; a coincident read is dropped
                if (bus.start) begin
                    state_d = RESET_HOLD;
                    launch  = 1'b1;
                end else if (bus.rd_en && (cnt_q != '0)) begin
                    do_read = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            cause_d = CAUSE_NONE;
        end
    end

    // State, halt cause, hold counter and registered core clear
    always_ff @(posedge clk) begin
        if (Clear) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            hold_q  <= '0;
            nclr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            nclr_q  <= (state_d == RUN) || (state_d == HALTED);
            if (launch) begin
                hold_q <= HOLD_LOAD;
            end else if (state_q == RESET_HOLD) begin
                hold_q <= hold_q - HOLD_W'(1);
            end
        end
    end

    // Per-sample bookkeeping: stall tracking and saturating cycle count
    always_ff @(posedge clk) begin
        if (Clear || launch) begin
            stall_q   <= '0;
            first_q   <= 1'b1;
            prev_pc_q <= '0;
            cyc_q     <= '0;
        end else if (sample) begin
            stall_q   <= stall_d;
            first_q   <= 1'b0;
            prev_pc_q <= bus.PC_next;
            if (cyc_q != '1) begin
                cyc_q <= cyc_q + 32'd1;
            end
        end
    end

    // Trace pointers and occupancy; a write into a full buffer drops the oldest
    always_ff @(posedge clk) begin
        if (Clear || launch) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (sample) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (cnt_q == FULL) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (do_read) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

    // Trace storage, written once per run cycle
    always_ff @(posedge clk) begin
        if (sample) begin
            mem[wr_ptr_q] <= {bus.PC_next, bus.write_back_data};
        end
    end

    // Registered readout of the oldest entry
    always_ff @(posedge clk) begin
        if (Clear) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= do_read;
            if (do_read) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end
    end

    assign bus.core_nClear = nclr_q;
    assign bus.core_en     = (state_q == RUN);
    assign bus.halted      = (state_q == HALTED);
    assign bus.halt_cause  = cause_q;
    assign bus.cycle_count = cyc_q;
    assign bus.trace_count = cnt_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;

endmodule
